// File: rtl/multiplexor_afisaj.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// One shared BCD decoder is time-multiplexed across the four digits. The
// inputs are captured once per frame so a digit never changes part-way
// through a scan, each slot starts with a short all-off gap against
// ghosting, and leading zeros can be suppressed. All pin outputs come
// straight from flops.
module multiplexor_afisaj #(
  parameter int DIV  = 2500,
  parameter int DEAD = 25
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] mii,
  input  logic [3:0] sute,
  input  logic [3:0] zeci,
  input  logic [3:0] unitati,
  input  logic       en,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  localparam int            CW       = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
  localparam bit            HAS_DEAD = (DEAD > 0);
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;
  localparam logic [6:0]    SEG_DASH = 7'b0111111;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   snapshot;      // {mii, sute, zeci, unitati}
  logic          load_pending;

  logic          slot_end;
  logic          load;
  logic [3:0]    cur_digit;
  logic          cur_blank;
  logic          in_dead;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;

  // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  function automatic logic [6:0] decode_bcd(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = SEG_DASH;
    endcase
    return p;
  endfunction

  assign slot_end = (cnt == CNT_LAST);
  // A snapshot is taken as the scan wraps back to the units digit, and once
  // right after reset so the display never starts from stale data.
  assign load     = load_pending || (slot_end && (idx == 2'd3));
  assign in_dead  = HAS_DEAD && (cnt < CNT_DEAD);

  // Select the current digit and decide whether it is a blanked leading zero.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cur_digit = snapshot[3:0];
    cur_blank = 1'b0;
    case (idx)
      2'd0: begin
        cur_digit = snapshot[3:0];
        cur_blank = 1'b0;
      end
      2'd1: begin
        cur_digit = snapshot[7:4];
        cur_blank = blank_lz && (snapshot[15:4] == 12'd0);
      end
      2'd2: begin
        cur_digit = snapshot[11:8];
        cur_blank = blank_lz && (snapshot[15:8] == 8'd0);
      end
      default: begin
        cur_digit = snapshot[15:12];
        cur_blank = blank_lz && (snapshot[15:12] == 4'd0);
      end
    endcase
  end

  // Next anode/segment values; the dead gap and the enable force all-off.
  always_comb begin
    an_next  = 4'b1111;
    seg_next = SEG_OFF;
    if (en && !in_dead) begin
      an_next          = 4'b1111;
      an_next[idx]     = 1'b0;
      seg_next         = cur_blank ? SEG_OFF : decode_bcd(cur_digit);
    end
  end

  // Prescaler and digit index; they keep running whatever en and blank_lz do.
  always_ff @(posedge clk or negedge clr) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!clr) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Frame-coherent capture of the four input digits.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      snapshot     <= 16'd0;
      load_pending <= 1'b1;
      frame_tick   <= 1'b0;
    end else begin
      frame_tick   <= load;
      load_pending <= 1'b0;
      if (load) begin
        snapshot <= {mii, sute, zeci, unitati};
      end
    end
  end

  // Registered pin drivers: one cycle of latency, glitch-free outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule
